// File: rtl/obstacle_monitor.sv
// Per-channel debounced near/clear stop decision with stale-sensor watchdog and nearest report.
// Latency: ch_stop/stale on the sampling edge, nearest one edge later; no backpressure.
module obstacle_monitor #(
   parameter int N_CH        = 3,
   parameter int DIST_W      = 12,
   parameter int STOP_CM     = 20,
   parameter int CLEAR_CM    = 30,
   parameter int DEBOUNCE    = 3,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [N_CH*DIST_W-1:0]                  distance,
   input  logic [N_CH-1:0]                         sample_valid,
   output logic [N_CH-1:0]                         ch_stop,
   output logic [N_CH-1:0]                         stale,
   output logic                                    stop_flag,
   output logic [DIST_W-1:0]                       nearest_dist,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] nearest_ch
);

   localparam int NCW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW  = $clog2(DEBOUNCE + 1);
   localparam int TW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [DIST_W-1:0] STOP_T    = DIST_W'(STOP_CM);
   localparam logic [DIST_W-1:0] CLEAR_T   = DIST_W'(CLEAR_CM);
   localparam logic [DIST_W-1:0] DIST_ONES = '1;
   localparam logic [CW-1:0]     DEB_T     = CW'(DEBOUNCE);
   localparam logic [TW-1:0]     TMAX      = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_ARMING,
      S_STOP,
      S_RELEASING
   } state_t;

   state_t              state_q [N_CH];
   state_t              state_d [N_CH];
   logic [CW-1:0]       cnt_q   [N_CH];
   logic [CW-1:0]       cnt_d   [N_CH];
   logic [TW-1:0]       tcnt_q  [N_CH];
   logic [TW-1:0]       tcnt_d  [N_CH];
   logic [DIST_W-1:0]   last_q  [N_CH];
   logic [DIST_W-1:0]   last_d  [N_CH];
   logic [DIST_W-1:0]   dist_ch [N_CH];

   logic [N_CH-1:0]     stale_q, stale_d;
   logic [N_CH-1:0]     ch_stop_q, ch_stop_d;
   logic [N_CH-1:0]     is_near, is_far, expire;
   logic [DIST_W-1:0]   nearest_dist_q, nearest_dist_d;
   logic [NCW-1:0]      nearest_ch_q, nearest_ch_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign dist_ch[g] = distance[g*DIST_W +: DIST_W];
      assign is_near[g] = (dist_ch[g] <= STOP_T);
      assign is_far[g]  = (dist_ch[g] >  CLEAR_T);
   end

   // Watchdog: expire fires only on the edge the counter first reaches TMAX;
   // a sample in that cycle clears the counter instead, so it wins.
   always_comb begin
      expire = '0;
      for (int i = 0; i < N_CH; i++) begin
         tcnt_d[i] = tcnt_q[i];
         if (TIMEOUT_CYC > 0) begin
            if (sample_valid[i]) begin
               tcnt_d[i] = '0;
            end else if (tcnt_q[i] != TMAX) begin
               tcnt_d[i] = tcnt_q[i] + TW'(1);
               expire[i] = (tcnt_q[i] + TW'(1) == TMAX);
            end
         end
      end
   end

   always_comb begin
      stale_d   = stale_q;
      ch_stop_d = ch_stop_q;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         last_d[i]  = last_q[i];
         if (sample_valid[i]) begin
            stale_d[i] = 1'b0;
            last_d[i]  = dist_ch[i];
            case (state_q[i])
               S_CLEAR: begin
                  if (is_near[i]) begin
                     if (DEBOUNCE == 1) begin
                        state_d[i] = S_STOP;
                        cnt_d[i]   = '0;
                     end else begin
                        state_d[i] = S_ARMING;
                        cnt_d[i]   = CW'(1);
                     end
                  end
               end
               S_ARMING: begin
                  if (!is_near[i]) begin
                     state_d[i] = S_CLEAR;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] + CW'(1) == DEB_T) begin
                     state_d[i] = S_STOP;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CW'(1);
                  end
               end
               S_STOP: begin
                  if (is_far[i]) begin
                     if (DEBOUNCE == 1) begin
                        state_d[i] = S_CLEAR;
                        cnt_d[i]   = '0;
                     end else begin
                        state_d[i] = S_RELEASING;
                        cnt_d[i]   = CW'(1);
                     end
                  end
               end
               S_RELEASING: begin
                  if (!is_far[i]) begin
                     state_d[i] = S_STOP;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] + CW'(1) == DEB_T) begin
                     state_d[i] = S_CLEAR;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CW'(1);
                  end
               end
               default: begin
                  state_d[i] = S_STOP;
                  cnt_d[i]   = '0;
               end
            endcase
         end else if (expire[i]) begin
            stale_d[i] = 1'b1;
            state_d[i] = S_STOP;
            cnt_d[i]   = '0;
         end
         ch_stop_d[i] = (state_d[i] == S_STOP) || (state_d[i] == S_RELEASING);
      end
   end

   // Strict less-than while scanning upward keeps ties on the lowest index.
   always_comb begin
      nearest_dist_d = last_q[0];
      nearest_ch_d   = '0;
      for (int i = 1; i < N_CH; i++) begin
         if (last_q[i] < nearest_dist_d) begin
            nearest_dist_d = last_q[i];
            nearest_ch_d   = NCW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= S_STOP;
            cnt_q[i]   <= '0;
            tcnt_q[i]  <= '0;
            last_q[i]  <= DIST_ONES;
         end
         stale_q        <= '0;
         ch_stop_q      <= '1;
         nearest_dist_q <= DIST_ONES;
         nearest_ch_q   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            tcnt_q[i]  <= tcnt_d[i];
            last_q[i]  <= last_d[i];
         end
         stale_q        <= stale_d;
         ch_stop_q      <= ch_stop_d;
         nearest_dist_q <= nearest_dist_d;
         nearest_ch_q   <= nearest_ch_d;
      end
   end

   assign ch_stop      = ch_stop_q;
   assign stale        = stale_q;
   assign stop_flag    = |ch_stop_q;
   assign nearest_dist = nearest_dist_q;
   assign nearest_ch   = nearest_ch_q;

endmodule

// File: tb/tb_obstacle_monitor.sv
// Bench for obstacle_monitor: directed vector table, hand-written corner sequences,
// then random traffic checked against a history-based reference model.
module tb_obstacle_monitor;

   localparam int NC  = 3;
   localparam int DW  = 12;
   localparam int DEB = 3;
   localparam int TO  = 100;

   logic            clk = 1'b0;
   logic            reset;
   logic [NC*DW-1:0] distance;
   logic [NC-1:0]   sample_valid;
   logic [NC-1:0]   ch_stop;
   logic [NC-1:0]   stale;
   logic            stop_flag;
   logic [DW-1:0]   nearest_dist;
   logic [1:0]      nearest_ch;

   obstacle_monitor #(
      .N_CH(NC), .DIST_W(DW), .STOP_CM(20), .CLEAR_CM(30),
      .DEBOUNCE(DEB), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .distance(distance), .sample_valid(sample_valid),
      .ch_stop(ch_stop), .stale(stale), .stop_flag(stop_flag),
      .nearest_dist(nearest_dist), .nearest_ch(nearest_ch)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_checks = 0;

   // Reference model: a channel changes state once its last DEB samples since
   // the previous change (or stale/reset) are all of the opposing class.
   bit          m_stop [NC];
   bit          m_stale[NC];
   int          m_idle [NC];
   logic [11:0] m_last [NC];
   int          hist   [NC][$];
   logic [11:0] m_nd;
   int          m_nc;

   typedef struct {
      logic [2:0]  v;
      logic [11:0] d0, d1, d2;
      logic [2:0]  exp_stop;
   } vec_t;
   vec_t tbl[$];

   function automatic int cls(input logic [11:0] d);
      if (d <= 12'd20) return 1;
      if (d > 12'd30) return 2;
      return 0;
   endfunction

   function automatic bit run_of(input int ch, input int c);
      if (hist[ch].size() < DEB) return 1'b0;
      for (int k = hist[ch].size() - DEB; k < hist[ch].size(); k++)
         if (hist[ch][k] != c) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_stop[i] = 1'b1; m_stale[i] = 1'b0; m_idle[i] = 0;
         m_last[i] = 12'hFFF; hist[i].delete();
      end
      m_nd = 12'hFFF; m_nc = 0;
   endtask

   task automatic model_edge(input logic [2:0] v, input logic [11:0] a, b, c);
      logic [11:0] d [NC];
      logic [11:0] best;
      int bc;
      d[0] = a; d[1] = b; d[2] = c;
      best = m_last[0]; bc = 0;
      for (int i = 1; i < NC; i++)
         if (m_last[i] < best) begin best = m_last[i]; bc = i; end
      m_nd = best; m_nc = bc;
      for (int i = 0; i < NC; i++) begin
         if (v[i]) begin
            m_idle[i] = 0; m_stale[i] = 1'b0; m_last[i] = d[i];
            hist[i].push_back(cls(d[i]));
            if (hist[i].size() > DEB) void'(hist[i].pop_front());
            if (!m_stop[i] && run_of(i, 1)) begin m_stop[i] = 1'b1; hist[i].delete(); end
            else if (m_stop[i] && run_of(i, 2)) begin m_stop[i] = 1'b0; hist[i].delete(); end
         end else if (m_idle[i] < TO) begin
            m_idle[i]++;
            if (m_idle[i] == TO) begin
               m_stale[i] = 1'b1; m_stop[i] = 1'b1; hist[i].delete();
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [2:0] ms, mst;
      for (int i = 0; i < NC; i++) begin ms[i] = m_stop[i]; mst[i] = m_stale[i]; end
      chk("mdl_ch_stop", 32'(ch_stop), 32'(ms));
      chk("mdl_stale", 32'(stale), 32'(mst));
      chk("mdl_stop_flag", 32'(stop_flag), 32'(|ms));
      chk("mdl_nearest_dist", 32'(nearest_dist), 32'(m_nd));
      chk("mdl_nearest_ch", 32'(nearest_ch), 32'(m_nc));
   endtask

   // Drive one cycle's inputs, let the edge happen, advance the model, settle.
   task automatic cyc(input logic [2:0] v, input logic [11:0] a, b, c);
      sample_valid = v;
      distance = {c, b, a};
      @(posedge clk);
      model_edge(v, a, b, c);
      #1;
      sample_valid = '0;
   endtask

   task automatic add(input logic [2:0] v, input logic [11:0] a, b, c, input logic [2:0] e);
      vec_t r;
      r.v = v; r.d0 = a; r.d1 = b; r.d2 = c; r.exp_stop = e;
      tbl.push_back(r);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ch_stop"}, 32'(ch_stop), 32'h7);
      chk({tag, "_stale"}, 32'(stale), 32'h0);
      chk({tag, "_stop_flag"}, 32'(stop_flag), 32'h1);
      chk({tag, "_nearest_dist"}, 32'(nearest_dist), 32'hFFF);
      chk({tag, "_nearest_ch"}, 32'(nearest_ch), 32'h0);
   endtask

   int          quiet[NC];
   logic [2:0]  rv;
   logic [11:0] rd [NC];

   initial begin
      reset = 1'b1; distance = '0; sample_valid = '0;
      model_reset();
      #2;
      check_reset_state("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Directed table: all-clear release, aborted arming, band samples.
      add(3'b111, 100, 100, 100, 3'b111);
      add(3'b111, 100, 100, 100, 3'b111);
      add(3'b111, 100, 100, 100, 3'b000);
      add(3'b010, 0, 15, 0, 3'b000);
      add(3'b010, 0, 15, 0, 3'b000);
      add(3'b010, 0, 40, 0, 3'b000);
      add(3'b010, 0, 15, 0, 3'b000);
      add(3'b010, 0, 15, 0, 3'b000);
      add(3'b010, 0, 15, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b011);
      for (int k = 0; k < 3; k++) add(3'b001, 25, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b010);
      add(3'b001, 10, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b011);
      add(3'b001, 25, 0, 0, 3'b011);
      add(3'b001, 31, 0, 0, 3'b011);
      foreach (tbl[r]) begin
         cyc(tbl[r].v, tbl[r].d0, tbl[r].d1, tbl[r].d2);
         chk($sformatf("tbl%0d_ch_stop", r), 32'(ch_stop), 32'(tbl[r].exp_stop));
         chk($sformatf("tbl%0d_stop_flag", r), 32'(stop_flag), 32'(|tbl[r].exp_stop));
      end

      // Watchdog expiry on ch2, then recovery through three far samples.
      cyc(3'b111, 100, 100, 100);
      for (int k = 1; k < TO; k++) begin
         cyc(3'b011, 100, 100, 0);
         check_model();
      end
      chk("wd_before_expiry_stale", 32'(stale), 32'h0);
      cyc(3'b011, 100, 100, 0);
      chk("wd_expiry_stale", 32'(stale), 32'h4);
      chk("wd_expiry_ch_stop2", 32'(ch_stop[2]), 32'h1);
      check_model();
      cyc(3'b111, 100, 100, 200);
      chk("wd_recover_stale", 32'(stale), 32'h0);
      chk("wd_recover1_ch_stop2", 32'(ch_stop[2]), 32'h1);
      cyc(3'b111, 100, 100, 200);
      chk("wd_recover2_ch_stop2", 32'(ch_stop[2]), 32'h1);
      cyc(3'b111, 100, 100, 200);
      chk("wd_recover3_ch_stop2", 32'(ch_stop[2]), 32'h0);
      check_model();

      // Sample landing on the expiry cycle wins over the watchdog.
      for (int k = 1; k < TO; k++) cyc(3'b011, 100, 100, 0);
      cyc(3'b111, 100, 100, 100);
      chk("wd_race_stale", 32'(stale), 32'h0);
      chk("wd_race_ch_stop2", 32'(ch_stop[2]), 32'h0);

      // Nearest report with a tie between ch1 and ch2.
      cyc(3'b111, 80, 45, 45);
      cyc(3'b000, 0, 0, 0);
      chk("near_dist", 32'(nearest_dist), 32'd45);
      chk("near_ch", 32'(nearest_ch), 32'd1);
      check_model();

      // Asynchronous reset in the middle of an arming run.
      cyc(3'b010, 0, 10, 0);
      chk("arming_ch_stop", 32'(ch_stop), 32'h0);
      #3 reset = 1'b1;
      #1;
      check_reset_state("async_reset");
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;

      // Random traffic with occasional long silences to exercise the watchdog.
      for (int i = 0; i < NC; i++) quiet[i] = 0;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < NC; i++) begin
            rv[i] = 1'b0;
            rd[i] = 12'($urandom_range(0, 4095));
            if (quiet[i] > 0) quiet[i]--;
            else if ($urandom_range(0, 149) == 0) quiet[i] = $urandom_range(95, 105);
            else rv[i] = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: rd[i] = 12'($urandom_range(0, 45));
               5: rd[i] = 12'd0;
               6: rd[i] = 12'($urandom_range(20, 21));
               7: rd[i] = 12'($urandom_range(30, 31));
               default: ;
            endcase
         end
         cyc(rv, rd[0], rd[1], rd[2]);
         check_model();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
